// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - shared rail indices, encodings and FSM states for the dual-rail sink
package dr_pkg;

   localparam int RAIL_NUM = 2;
   localparam int RAIL0    = 0;
   localparam int RAIL1    = 1;

   typedef logic [RAIL_NUM-1:0] dr_bit_t;

   localparam logic [15:0] ENC_TP = "TP";
   localparam logic [15:0] ENC_FP = "FP";

   typedef enum logic [1:0] {
      WAIT_DATA   = 2'd0,
      ACK         = 2'd1,
      WAIT_SPACER = 2'd2
   } dr_sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with registered head and same-cycle push/pop
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr_n;
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
         // Write-through when the incoming word becomes the new head.
         head   <= (do_push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
      end
   end

endmodule

// File: rtl/dr_sync_sink.sv
// rtl/dr_sync_sink.sv - synchronizes a dual-rail token link, confirms completion and
// queues decoded words; the producer ack is withheld while the FIFO cannot accept.
module dr_sync_sink
   import dr_pkg::*;
#(
   parameter logic [15:0] ENC         = ENC_TP,
   parameter int          WIDTH       = 32,
   parameter int          DEPTH       = 4,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0][1:0] in,
   output logic                  ack_o,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           tok_cnt
);
   localparam bit IS_TP = (ENC == ENC_TP);

   dr_bit_t [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   dr_bit_t [WIDTH-1:0]                  s;

   dr_sink_state_t   state;
   dr_sink_state_t   state_n;
   logic             phase;
   logic             phase_n;
   logic             ack_n;
   logic [WIDTH-1:0] prev_r1;
   logic [WIDTH-1:0] rail1;
   logic [WIDTH-1:0] bit_done;
   logic [WIDTH-1:0] spacer_bits;
   logic [WIDTH-1:0] decoded;
   logic [WIDTH-1:0] cap_q;
   logic             word_done;
   logic             spacer;
   logic             done_q;
   logic             spacer_q;
   logic             capture;
   logic             push;
   logic             load_prev;
   logic             pop;
   logic             push_ok;
   logic             fifo_full;
   logic             fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      bit_done    = '0;
      spacer_bits = '0;
      decoded     = '0;
      rail1       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rail1[i]       = s[i][RAIL1];
         spacer_bits[i] = ~(s[i][RAIL1] | s[i][RAIL0]);
         if (IS_TP) begin
            bit_done[i] = (s[i][RAIL1] ^ s[i][RAIL0]) != phase;
            decoded[i]  = s[i][RAIL1] ^ prev_r1[i];
         end else begin
            bit_done[i] = s[i][RAIL1] ^ s[i][RAIL0];
            decoded[i]  = s[i][RAIL1];
         end
      end
   end

   assign word_done = &bit_done;
   assign spacer    = &spacer_bits;

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid && out_ready;
   assign push_ok   = !fifo_full || pop;

   always_comb begin
      state_n   = state;
      ack_n     = ack_o;
      phase_n   = phase;
      capture   = 1'b0;
      push      = 1'b0;
      load_prev = 1'b0;
      case (state)
         WAIT_DATA: begin
            // done_q demands the word be complete on the previous cycle too.
            if (word_done && done_q && push_ok) begin
               capture = 1'b1;
               state_n = ACK;
            end
         end
         ACK: begin
            push = 1'b1;
            if (IS_TP) begin
               ack_n     = ~ack_o;
               phase_n   = ~phase;
               load_prev = 1'b1;
               state_n   = WAIT_DATA;
            end else begin
               ack_n   = 1'b1;
               state_n = WAIT_SPACER;
            end
         end
         WAIT_SPACER: begin
            if (spacer && spacer_q) begin
               ack_n   = 1'b0;
               state_n = WAIT_DATA;
            end
         end
         default: state_n = WAIT_DATA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= WAIT_DATA;
         ack_o    <= 1'b0;
         phase    <= 1'b0;
         prev_r1  <= '0;
         done_q   <= 1'b0;
         spacer_q <= 1'b0;
         cap_q    <= '0;
         tok_cnt  <= '0;
      end else begin
         state    <= state_n;
         ack_o    <= ack_n;
         phase    <= phase_n;
         done_q   <= (state == WAIT_DATA) && word_done;
         spacer_q <= (state == WAIT_SPACER) && spacer;
         if (load_prev) prev_r1 <= rail1;
         if (capture) begin
            cap_q   <= decoded;
            tok_cnt <= tok_cnt + 16'd1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (cap_q),
      .pop       (pop),
      .head      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
